// File: rtl/rv32_ahb_lite_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for rv32_ahb_lite_sram_slave.
// HREADY is the interconnect's combined ready, driven from the master side.
interface rv32_ahb_lite_sram_slave_if #(
  parameter int unsigned XLEN = 32
);
  logic            HSEL;
  logic [XLEN-1:0] HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [XLEN-1:0] HWDATA;
  logic            HREADY;
  logic            HREADYOUT;
  logic [XLEN-1:0] HRDATA;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/rv32_ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with 0..15 wait states, byte lanes, write-to-read forwarding and ERROR response.
// Optional write protection of the low ROM_WORDS words: define AHB_SRAM_WPROT_EN.
module rv32_ahb_lite_sram_slave #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ROM_WORDS   = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rv32_ahb_lite_sram_slave_if.slave    s_ahb
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef AHB_SRAM_WPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic            w_ready;
  logic            w_resp;
  logic            w_accept;
  logic            w_err;
  logic            w_prot;
  logic            w_we;
  logic            w_load_rd;
  logic [29:0]     w_word;
  logic [3:0]      w_be;
  logic [AW-1:0]   w_rd_idx;
  logic [XLEN-1:0] w_rd_word;
  logic            w_unused;

  assign w_unused = s_ahb.HTRANS[0];

  // Address-phase decode: lane enables and the error decision
  always_comb begin
    w_word = s_ahb.HADDR[XLEN-1:2];
    case (s_ahb.HSIZE)
      3'b000:  w_be = 4'b0001 << s_ahb.HADDR[1:0];
      3'b001:  w_be = s_ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
    w_prot = PROT_EN && s_ahb.HWRITE && (w_word < 30'(ROM_WORDS));
    w_err  = (s_ahb.HSIZE > 3'b010)
          || ((s_ahb.HSIZE == 3'b001) && s_ahb.HADDR[0])
          || ((s_ahb.HSIZE == 3'b010) && (s_ahb.HADDR[1:0] != 2'b00))
          || (w_word >= 30'(DEPTH_WORDS))
          || w_prot;
  end

  assign w_accept = s_ahb.HSEL && s_ahb.HTRANS[1] && s_ahb.HREADY && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: if (r_cnt <= 4'd1) w_next = S_ACCESS;
      S_ERR1: w_next = S_ERR2;
      S_IDLE, S_ACCESS, S_ERR2: begin
        if (!w_accept)              w_next = S_IDLE;
        else if (w_err)             w_next = S_ERR1;
        else if (WAIT_STATES == 0)  w_next = S_ACCESS;
        else                        w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b1;
    w_resp  = 1'b0;
    case (r_state)
      S_WAIT:  w_ready = 1'b0;
      S_ERR1:  begin w_ready = 1'b0; w_resp = 1'b1; end
      S_ERR2:  w_resp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_write <= s_ahb.HWRITE;
      r_idx   <= s_ahb.HADDR[AW+1:2];
      r_be    <= w_be;
      r_cnt   <= 4'(WAIT_STATES);
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Read data is loaded on the edge entering ACCESS so it is stable for the whole ready cycle;
  // with zero wait states that edge is the read's address phase, possibly a write's completion.
  assign w_we      = (r_state == S_ACCESS) && r_write;
  assign w_load_rd = (w_accept && !w_err && !s_ahb.HWRITE && (WAIT_STATES == 0))
                  || ((r_state == S_WAIT) && (r_cnt <= 4'd1) && !r_write);
  assign w_rd_idx  = (r_state == S_WAIT) ? r_idx : s_ahb.HADDR[AW+1:2];

  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_we && (r_idx == w_rd_idx)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_be[b]) w_rd_word[8*b +: 8] = s_ahb.HWDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rdata <= '0;
    else if (w_load_rd) r_rdata <= w_rd_word;
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= s_ahb.HWDATA[8*b +: 8];
      end
    end
  end

  assign s_ahb.HREADYOUT = w_ready;
  assign s_ahb.HRESP     = w_resp;
  assign s_ahb.HRDATA    = r_rdata;

endmodule

// File: doc/rv32_ahb_lite_sram_slave.md
Name: rv32_ahb_lite_sram_slave

Overview:
Zero-to-N wait-state AHB-Lite slave that fronts the unified on-chip SRAM used by the RV32IM core's bus master.
- Implements the full address/data pipeline: captures the address phase, completes writes with per-byte lanes, and returns read data in the data phase.
- Forwards read-after-write data between back-to-back accesses.
- Issues the two-cycle AHB-Lite ERROR response for illegal transfers.
- Sits between the SoC interconnect/decoder (which drives HSEL) and the storage array held inside this block.

Parameters:
XLEN, 32, data bus width (fixed at 32; other values unsupported)
DEPTH_WORDS, 4096, SRAM depth in 32-bit words; byte address range 0 .. 4*DEPTH_WORDS-1
WAIT_STATES, 0, data-phase wait cycles (HREADYOUT low) per OKAY transfer, 0..15
ROM_WORDS, 256, size in words of the write-protected low region (used only with the optional feature)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
HSEL  input  1  slave select from address decoder
HADDR  input  XLEN  byte address (address phase)
HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1 = write
HSIZE  input  3  000 byte, 001 half, 010 word
HWDATA  input  XLEN  write data (data phase)
HREADY  input  1  bus-wide ready (previous transfer completing)
HREADYOUT  output  1  this slave's ready
HRDATA  output  XLEN  read data
HRESP  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (async, any state): HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0, pending-write=0. Array contents are not reset. A transfer in flight at reset is abandoned and no write occurs.
- Accept rule: a transfer is accepted on a clock edge where HSEL & HTRANS[1] & HREADY. On acceptance, register addr, write, size, and the error decision.
- Other cases: HSEL with IDLE/BUSY, or HSEL=0, gives an OKAY zero-wait data phase with no array access.
- Error conditions, evaluated at the address phase:
  - HSIZE > 010
  - half with HADDR[0]=1
  - word with HADDR[1:0]!=00
  - word index HADDR[31:2] >= DEPTH_WORDS
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On accept: error -> ERR1; WAIT_STATES=0 -> ACCESS completes this cycle; else -> WAIT with counter=WAIT_STATES.
  - WAIT: HREADYOUT=0. Counter decrements each cycle; on reaching 1 -> ACCESS next cycle.
  - ACCESS: HREADYOUT=1, HRESP=0. The data phase completes. A new transfer may be accepted on the same edge (pipelined).
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. May accept the next transfer on the same edge.
- Latency: with WAIT_STATES=0, every transfer occupies exactly one data-phase cycle, so back-to-back NONSEQ transfers run at full throughput. With WAIT_STATES=N, the data phase is N+1 cycles.
- Write data capture: sampled from HWDATA on the completing data-phase edge.
- Byte lanes:
  - byte: lane HADDR[1:0]
  - half: lanes {HADDR[1],0} and {HADDR[1],1}
  - word: all 4 lanes
  - Only the enabled lanes are updated.
- Errored transfers never write. HRDATA holds its previous value for errored reads and for writes.
- Reads: HRDATA is valid while HREADYOUT=1 in the completing data-phase cycle and holds until the next read completes. The full 32-bit word is returned; the master performs lane extraction.
- Forwarding: if a read's address phase overlaps the data phase of a write to the same word index, the written lanes are merged into the read result. The read returns the new data, never stale data.
- HREADY low with HSEL high: hold address-phase inputs ignored; no acceptance.

Optional Feature:
AHB_SRAM_WPROT_EN
- Defined: any accepted write whose word index < ROM_WORDS is treated as an error condition, giving the two-cycle ERROR response with the array unchanged. Reads of that region remain OKAY.
- Undefined: the whole array is writable; ROM_WORDS is ignored.

Test Plan:
- WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 every cycle, HRESP=0.
- Byte write HSIZE=000, HADDR=0x11, HWDATA=0x0000AA00 over word 0xDEADBEEF -> read 0x10 returns 0xDEADAAEF. Half write 0x12 with 0x12340000 -> 0x1234AAEF.
- Back-to-back write 0x20=0xCAFEF00D immediately followed by read 0x20 (address phase overlapping the write data phase) -> read returns 0xCAFEF00D.
- Word access to 0x22, and word read at byte address 4*DEPTH_WORDS -> HREADYOUT 0 then 1 with HRESP=1 both cycles; memory at 0x20 unchanged; next transfer proceeds OKAY.
- WAIT_STATES=2: single read -> HREADYOUT low exactly 2 cycles then high with data. Assert rst_n=0 mid-WAIT on a write -> HREADYOUT=1, HRESP=0 immediately, and the target word is unmodified.
- With AHB_SRAM_WPROT_EN, ROM_WORDS=256: write to 0x3FC -> ERROR, data unchanged. Write to 0x400 -> OKAY, data written.
